// File: rtl/imem_banked_wrap.sv
// Banked instruction memory. A read-only fetch port and a queued ring RD/WR port share
// NUM_BANKS word-interleaved banks. Fetch wins bank conflicts until the queue head has starved.
package imem_banked_wrap_pkg;
  typedef enum logic [1:0] {
    OP_RD    = 2'd0,
    OP_WR    = 2'd1,
    OP_RSVD2 = 2'd2,
    OP_RSVD3 = 2'd3
  } t_opcode;

  localparam int MSB_REGION = 31;
  localparam int LSB_REGION = 24;
  localparam logic [MSB_REGION-LSB_REGION:0] I_MEM_REGION = 8'h01;
endpackage

module imem_banked_wrap
  import imem_banked_wrap_pkg::*;
#(
  parameter int NUM_BANKS    = 2,
  parameter int DEPTH_WORDS  = 2048,
  parameter int RQ_DEPTH     = 4,
  parameter int STARVE_LIMIT = 7
) (
  input  logic        QClk,
  input  logic        RstQnnnH,
  input  logic [31:0] PcQ100H,
  input  logic        RdEnableQ100H,
  output logic [31:0] InstFetchQ101H,
  output logic        InstFetchValidQ101H,
  input  logic        F2C_ReqValidQ503H,
  input  t_opcode     F2C_ReqOpcodeQ503H,
  input  logic [31:0] F2C_ReqAddressQ503H,
  input  logic [31:0] F2C_ReqDataQ503H,
  input  logic [3:0]  F2C_ReqByteEnQ503H,
  output logic        F2C_ReqReadyQ503H,
  output logic        F2C_RspIMemValidQ504H,
  output logic [31:0] F2C_I_MemRspDataQ504H
);
  localparam int WIDX       = $clog2(DEPTH_WORDS);
  localparam int LOG2B      = $clog2(NUM_BANKS);
  localparam int BW         = (LOG2B > 0) ? LOG2B : 1;
  localparam int BANK_DEPTH = DEPTH_WORDS / NUM_BANKS;
  localparam int RW         = (WIDX > LOG2B) ? WIDX - LOG2B : 1;
  localparam int PW         = $clog2(RQ_DEPTH);
  localparam int CW         = PW + 1;
  localparam logic [CW-1:0] Q_FULL     = CW'(RQ_DEPTH);
  localparam logic [7:0]    STARVE_MAX = 8'(STARVE_LIMIT);

  typedef struct packed {
    logic            wr;
    logic [WIDX-1:0] idx;
    logic [31:0]     dat;
    logic [3:0]      be;
  } rq_entry_t;

  function automatic logic [BW-1:0] bank_of(input logic [WIDX-1:0] idx);
    return (LOG2B == 0) ? '0 : idx[BW-1:0];
  endfunction

  function automatic logic [RW-1:0] row_of(input logic [WIDX-1:0] idx);
    return RW'(idx >> LOG2B);
  endfunction

  logic [31:0] mem_q [NUM_BANKS][BANK_DEPTH];
  rq_entry_t   rq_q  [RQ_DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    starve_q, starve_d;
  logic          inst_vld_q, inst_vld_d, rsp_vld_q, rsp_vld_d;
  logic [31:0]   inst_dat_q, inst_dat_d, rsp_dat_q, rsp_dat_d;

  rq_entry_t       in_entry, head;
  logic            q_empty, op_ok, region_ok, accept, head_vld;
  logic            conflict, starved, issue, fetch_grant, push, pop;
  logic [WIDX-1:0] fetch_idx;
  logic [BW-1:0]   fetch_bank, head_bank;
  logic [RW-1:0]   fetch_row, head_row;
  logic [31:0]     fetch_word, head_word;
  logic            unused_bits;

  assign unused_bits = ^{PcQ100H, F2C_ReqAddressQ503H};

  assign in_entry.wr  = (F2C_ReqOpcodeQ503H == OP_WR);
  assign in_entry.idx = F2C_ReqAddressQ503H[WIDX+1:2];
  assign in_entry.dat = F2C_ReqDataQ503H;
  assign in_entry.be  = F2C_ReqByteEnQ503H;

  assign F2C_ReqReadyQ503H = (cnt_q != Q_FULL);
  assign q_empty   = (cnt_q == '0);
  assign op_ok     = (F2C_ReqOpcodeQ503H == OP_RD) || (F2C_ReqOpcodeQ503H == OP_WR);
  assign region_ok = (F2C_ReqAddressQ503H[MSB_REGION:LSB_REGION] == I_MEM_REGION);
  assign accept    = RstQnnnH & F2C_ReqValidQ503H & F2C_ReqReadyQ503H & op_ok & region_ok;

  // An accept into an empty queue presents itself as head in the same cycle.
  assign head     = q_empty ? in_entry : rq_q[rd_ptr_q];
  assign head_vld = RstQnnnH & (~q_empty | accept);

  assign fetch_idx  = PcQ100H[WIDX+1:2];
  assign fetch_bank = bank_of(fetch_idx);
  assign fetch_row  = row_of(fetch_idx);
  assign head_bank  = bank_of(head.idx);
  assign head_row   = row_of(head.idx);
  assign fetch_word = mem_q[fetch_bank][fetch_row];
  assign head_word  = mem_q[head_bank][head_row];

  assign conflict    = head_vld & RdEnableQ100H & (fetch_bank == head_bank);
  assign starved     = (starve_q == STARVE_MAX);
  assign issue       = head_vld & (~conflict | starved);
  assign fetch_grant = RstQnnnH & RdEnableQ100H & ~(conflict & starved);
  assign push        = accept & ~(q_empty & issue);
  assign pop         = issue & ~q_empty;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    starve_d   = starve_q;
    inst_dat_d = inst_dat_q;
    rsp_dat_d  = rsp_dat_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    cnt_d = cnt_q + CW'(push) - CW'(pop);
    if (issue)         starve_d = '0;
    else if (conflict) starve_d = starve_q + 8'd1;
    inst_vld_d = fetch_grant;
    if (fetch_grant) inst_dat_d = fetch_word;
    rsp_vld_d = issue & ~head.wr;
    if (rsp_vld_d) rsp_dat_d = head_word;
  end

  always_ff @(posedge QClk) begin
    if (!RstQnnnH) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      starve_q   <= '0;
      inst_vld_q <= 1'b0;
      inst_dat_q <= '0;
      rsp_vld_q  <= 1'b0;
      rsp_dat_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      starve_q   <= starve_d;
      inst_vld_q <= inst_vld_d;
      inst_dat_q <= inst_dat_d;
      rsp_vld_q  <= rsp_vld_d;
      rsp_dat_q  <= rsp_dat_d;
    end
  end

  // Storage arrays are not reset: memory contents must survive reset.
  always_ff @(posedge QClk) begin
    if (push) rq_q[wr_ptr_q] <= in_entry;
  end

  always_ff @(posedge QClk) begin
    if (issue && head.wr) begin
      for (int b = 0; b < 4; b++) begin
        if (head.be[b]) mem_q[head_bank][head_row][8*b +: 8] <= head.dat[8*b +: 8];
      end
    end
  end

  assign InstFetchQ101H        = inst_dat_q;
  assign InstFetchValidQ101H   = inst_vld_q;
  assign F2C_RspIMemValidQ504H = rsp_vld_q;
  assign F2C_I_MemRspDataQ504H = rsp_dat_q;
endmodule

// File: tb/tb_imem_banked_wrap.sv
// Bench for imem_banked_wrap: directed scenarios then random traffic, all cycles checked
// against a queue-based reference model of the shared memory.
module tb_imem_banked_wrap;
  import imem_banked_wrap_pkg::*;

  localparam int NB = 2;
  localparam int DW = 2048;
  localparam int RQ = 4;
  localparam int SL = 7;

  logic        QClk = 1'b0;
  logic        RstQnnnH;
  logic [31:0] PcQ100H;
  logic        RdEnableQ100H;
  logic [31:0] InstFetchQ101H;
  logic        InstFetchValidQ101H;
  logic        F2C_ReqValidQ503H;
  t_opcode     F2C_ReqOpcodeQ503H;
  logic [31:0] F2C_ReqAddressQ503H;
  logic [31:0] F2C_ReqDataQ503H;
  logic [3:0]  F2C_ReqByteEnQ503H;
  logic        F2C_ReqReadyQ503H;
  logic        F2C_RspIMemValidQ504H;
  logic [31:0] F2C_I_MemRspDataQ504H;

  always #5 QClk = ~QClk;

  imem_banked_wrap #(
    .NUM_BANKS(NB), .DEPTH_WORDS(DW), .RQ_DEPTH(RQ), .STARVE_LIMIT(SL)
  ) dut (
    .QClk(QClk),
    .RstQnnnH(RstQnnnH),
    .PcQ100H(PcQ100H),
    .RdEnableQ100H(RdEnableQ100H),
    .InstFetchQ101H(InstFetchQ101H),
    .InstFetchValidQ101H(InstFetchValidQ101H),
    .F2C_ReqValidQ503H(F2C_ReqValidQ503H),
    .F2C_ReqOpcodeQ503H(F2C_ReqOpcodeQ503H),
    .F2C_ReqAddressQ503H(F2C_ReqAddressQ503H),
    .F2C_ReqDataQ503H(F2C_ReqDataQ503H),
    .F2C_ReqByteEnQ503H(F2C_ReqByteEnQ503H),
    .F2C_ReqReadyQ503H(F2C_ReqReadyQ503H),
    .F2C_RspIMemValidQ504H(F2C_RspIMemValidQ504H),
    .F2C_I_MemRspDataQ504H(F2C_I_MemRspDataQ504H)
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: pending ring requests in acceptance order plus a flat word memory.
  typedef struct {
    bit          wr;
    int          word;
    logic [31:0] data;
    logic [3:0]  be;
  } req_t;

  req_t        mq[$];
  int          starve;
  logic [31:0] mem_m [64];
  logic        e_ivld, e_rvld;
  logic [31:0] e_inst, e_rdat;

  task automatic fetch(input bit en, input int word);
    RdEnableQ100H = en;
    PcQ100H = 32'(word * 4);
  endtask

  task automatic drive_req(input bit v, input t_opcode op, input int word,
                           input logic [31:0] d, input logic [3:0] be, input logic [7:0] region);
    F2C_ReqValidQ503H   = v;
    F2C_ReqOpcodeQ503H  = op;
    F2C_ReqAddressQ503H = {region, 24'(word * 4)};
    F2C_ReqDataQ503H    = d;
    F2C_ReqByteEnQ503H  = be;
  endtask

  task automatic idle_req();
    F2C_ReqValidQ503H = 1'b0;
  endtask

  // Apply the current inputs for one clock, advance the model, check all outputs.
  task automatic cycle();
    req_t        r, h;
    bit          fok, riss, clash;
    int          pcw;
    logic [31:0] fetched;
    pcw  = int'(PcQ100H[12:2]);
    fok  = 1'b0;
    riss = 1'b0;
    if (!RstQnnnH) begin
      mq.delete();
      starve = 0;
      e_ivld = 1'b0; e_inst = '0; e_rvld = 1'b0; e_rdat = '0;
    end else begin
      chk("ready", 32'(F2C_ReqReadyQ503H), 32'(mq.size() < RQ));
      if (F2C_ReqValidQ503H && mq.size() < RQ &&
          (F2C_ReqOpcodeQ503H == OP_RD || F2C_ReqOpcodeQ503H == OP_WR) &&
          F2C_ReqAddressQ503H[31:24] == I_MEM_REGION) begin
        r.wr   = (F2C_ReqOpcodeQ503H == OP_WR);
        r.word = int'(F2C_ReqAddressQ503H[12:2]);
        r.data = F2C_ReqDataQ503H;
        r.be   = F2C_ReqByteEnQ503H;
        mq.push_back(r);
      end
      fok     = RdEnableQ100H;
      fetched = mem_m[pcw];
      if (mq.size() > 0) begin
        clash = RdEnableQ100H && ((mq[0].word % NB) == (pcw % NB));
        if (clash && starve < SL) begin
          starve++;
        end else begin
          h = mq.pop_front();
          starve = 0;
          if (clash) fok = 1'b0;
          if (h.wr) begin
            for (int b = 0; b < 4; b++) begin
              if (h.be[b]) mem_m[h.word][8*b +: 8] = h.data[8*b +: 8];
            end
          end else begin
            riss   = 1'b1;
            e_rdat = mem_m[h.word];
          end
        end
      end
      e_ivld = fok;
      if (fok) e_inst = fetched;
      e_rvld = riss;
    end
    @(posedge QClk);
    #1;
    chk("inst_vld", 32'(InstFetchValidQ101H), 32'(e_ivld));
    chk("inst_dat", InstFetchQ101H, e_inst);
    chk("rsp_vld", 32'(F2C_RspIMemValidQ504H), 32'(e_rvld));
    if (e_rvld) chk("rsp_dat", F2C_I_MemRspDataQ504H, e_rdat);
  endtask

  initial begin
    int  n_valid, n_acc, n_rsp, widx;
    bit  dropped;
    int  bank0_words[7];
    t_opcode rop;
    logic [7:0] rreg;

    bank0_words = '{0, 2, 6, 8, 10, 12, 14};
    for (int i = 0; i < 64; i++) mem_m[i] = 'x;
    RstQnnnH = 1'b0;
    fetch(0, 0);
    drive_req(0, OP_RD, 0, '0, '0, I_MEM_REGION);

    // Reset state
    cycle();
    cycle();
    chk("rst_ready", 32'(F2C_ReqReadyQ503H), 32'd1);
    chk("rst_rsp_dat", F2C_I_MemRspDataQ504H, 32'd0);
    chk("rst_inst_dat", InstFetchQ101H, 32'd0);
    RstQnnnH = 1'b1;

    // Prefill words 0..15 over the ring, core idle
    for (int i = 0; i < 16; i++) begin
      drive_req(1, OP_WR, i, 32'hC0DE0000 ^ (32'(i) * 32'h00010203), 4'hF, I_MEM_REGION);
      cycle();
    end
    idle_req();
    cycle();

    // Write then read word 5, idle core: response one cycle after issue
    drive_req(1, OP_WR, 5, 32'hDEADBEEF, 4'hF, I_MEM_REGION);
    cycle();
    drive_req(1, OP_RD, 5, '0, '0, I_MEM_REGION);
    cycle();
    chk("rd5_vld", 32'(F2C_RspIMemValidQ504H), 32'd1);
    chk("rd5_dat", F2C_I_MemRspDataQ504H, 32'hDEADBEEF);
    idle_req();
    cycle();

    // Partial byte-enable write
    drive_req(1, OP_WR, 2, 32'h11223344, 4'hF, I_MEM_REGION);
    cycle();
    drive_req(1, OP_WR, 2, 32'hAABBCCDD, 4'b0010, I_MEM_REGION);
    cycle();
    drive_req(1, OP_RD, 2, '0, '0, I_MEM_REGION);
    cycle();
    chk("be_merge_dat", F2C_I_MemRspDataQ504H, 32'h1122CC44);
    idle_req();
    cycle();

    // Different banks served concurrently
    fetch(1, 3);
    drive_req(1, OP_RD, 8, '0, '0, I_MEM_REGION);
    cycle();
    chk("conc_inst_vld", 32'(InstFetchValidQ101H), 32'd1);
    chk("conc_rsp_vld", 32'(F2C_RspIMemValidQ504H), 32'd1);
    idle_req();
    fetch(0, 0);
    cycle();

    // Starvation: fetch bank 0 every cycle, ring RD to bank 0
    fetch(1, 4);
    drive_req(1, OP_RD, 6, '0, '0, I_MEM_REGION);
    n_valid = 0;
    for (int i = 0; i < 30; i++) begin
      cycle();
      idle_req();
      if (!InstFetchValidQ101H) break;
      n_valid++;
    end
    chk("starve_valid_fetches", 32'(n_valid), 32'd7);
    chk("starve_fetch_dropped", 32'(InstFetchValidQ101H), 32'd0);
    chk("starve_rsp_vld", 32'(F2C_RspIMemValidQ504H), 32'd1);
    cycle();
    chk("starve_fetch_resumes", 32'(InstFetchValidQ101H), 32'd1);

    // Queue fill under constant conflicting fetch
    n_acc = 0; n_rsp = 0; dropped = 1'b0; widx = 0;
    for (int i = 0; i < 48; i++) begin
      if (!F2C_ReqReadyQ503H && !dropped) begin
        dropped = 1'b1;
        chk("accepts_before_full", 32'(n_acc), 32'd4);
      end
      drive_req(1, OP_RD, bank0_words[widx % 7], '0, '0, I_MEM_REGION);
      if (F2C_ReqReadyQ503H) begin
        n_acc++;
        widx++;
      end
      cycle();
      if (F2C_RspIMemValidQ504H) n_rsp++;
    end
    chk("ready_dropped", 32'(dropped), 32'd1);
    idle_req();
    fetch(0, 0);
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (F2C_RspIMemValidQ504H) n_rsp++;
    end
    chk("no_loss", 32'(n_rsp), 32'(n_acc));

    // Reset with three queued requests, including a pending write to word 5
    fetch(1, 4);
    drive_req(1, OP_RD, 6, '0, '0, I_MEM_REGION);
    cycle();
    drive_req(1, OP_WR, 5, 32'h55555555, 4'hF, I_MEM_REGION);
    cycle();
    drive_req(1, OP_RD, 8, '0, '0, I_MEM_REGION);
    cycle();
    idle_req();
    RstQnnnH = 1'b0;
    cycle();
    RstQnnnH = 1'b1;
    fetch(0, 0);
    chk("ready_after_rst", 32'(F2C_ReqReadyQ503H), 32'd1);
    n_rsp = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (F2C_RspIMemValidQ504H) n_rsp++;
    end
    chk("rst_no_rsp", 32'(n_rsp), 32'd0);
    drive_req(1, OP_RD, 5, '0, '0, I_MEM_REGION);
    cycle();
    chk("rst_old_vld", 32'(F2C_RspIMemValidQ504H), 32'd1);
    chk("rst_old_dat", F2C_I_MemRspDataQ504H, 32'hDEADBEEF);

    // Dropped requests: foreign region and reserved opcode
    drive_req(1, OP_WR, 5, 32'h0BADF00D, 4'hF, 8'h7F);
    cycle();
    chk("drop_region_rsp", 32'(F2C_RspIMemValidQ504H), 32'd0);
    drive_req(1, OP_RSVD2, 5, 32'h0BADF00D, 4'hF, I_MEM_REGION);
    cycle();
    drive_req(1, OP_RD, 5, '0, '0, I_MEM_REGION);
    cycle();
    chk("drop_keeps_dat", F2C_I_MemRspDataQ504H, 32'hDEADBEEF);
    idle_req();
    cycle();

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      fetch(1'($urandom_range(0, 1)), $urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) rop = OP_RSVD2;
      else rop = ($urandom_range(0, 1) == 1) ? OP_RD : OP_WR;
      rreg = ($urandom_range(0, 7) == 0) ? 8'h7F : I_MEM_REGION;
      drive_req(1'($urandom_range(0, 1)), rop, $urandom_range(0, 15), $urandom,
                4'($urandom), rreg);
      cycle();
    end
    idle_req();
    fetch(0, 0);
    for (int i = 0; i < 40; i++) cycle();
    chk("final_drain_ready", 32'(F2C_ReqReadyQ503H), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
